// File: rtl/serial_add_pkg.sv
// -----------------------------------------------------------------------------
// serial_add_pkg
// Shared types and constants for the bit-serial adder.
//   state_t    : controller states (IDLE, RUN, DONE)
//   DEF_WIDTH  : default operand/sum width
//   CNT_W      : bit-counter width for the default width
//   cnt_width(): bit-counter width for an arbitrary width (minimum 1 bit)
// -----------------------------------------------------------------------------
package serial_add_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int CNT_W     = $clog2(DEF_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/full_adder_bit.sv
// -----------------------------------------------------------------------------
// full_adder_bit
// Single combinational full-adder cell used by the serial datapath.
//   x, y : operand bits
//   ci   : carry in
//   s    : sum bit
//   co   : carry out (majority of x, y, ci)
// -----------------------------------------------------------------------------
module full_adder_bit (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (x & ci) | (y & ci);

endmodule

// File: rtl/serial_adder4.sv
// -----------------------------------------------------------------------------
// serial_adder4
// Bit-serial, LSB-first adder. Operands and carry-in are captured on an
// accepted start; one bit is added per clock through a single full-adder
// cell; the registered sum, carry-out and signed overflow are published
// together with a one-cycle done pulse.
//
// Optional build macro SERIAL_SUB_MODE_EN adds the 'sub' input: when set at
// start, b is inverted and the carry is seeded with 1, giving a - b.
//
// Ports:
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset
//   start : request, sampled only in IDLE
//   a, b  : WIDTH-bit operands, captured on accepted start
//   cin   : carry-in, captured on accepted start
//   sub   : (SERIAL_SUB_MODE_EN only) subtract select
//   busy  : high in RUN and DONE
//   done  : one-cycle result-valid pulse
//   sum   : registered result, held until the next completion
//   cout  : carry out of the MSB
//   ovf   : signed overflow (carry into MSB xor carry out of MSB)
// -----------------------------------------------------------------------------
module serial_adder4
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_SUB_MODE_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr;
  logic [WIDTH-1:0] res_next;
  logic [CW-1:0]    bitcnt;
  logic             carry;
  logic             fa_s, fa_co;
  logic [WIDTH-1:0] b_cap;
  logic             carry_cap;
  logic             last_bit;

`ifdef SERIAL_SUB_MODE_EN
  // Two's-complement subtract: a + ~b + 1, so cin is ignored in this mode.
  assign b_cap     = sub ? ~b : b;
  assign carry_cap = sub ? 1'b1 : cin;
`else
  assign b_cap     = b;
  assign carry_cap = cin;
`endif

  full_adder_bit u_fa (
    .x  (a_sr[0]),
    .y  (b_sr[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  assign last_bit = (bitcnt == LAST_BIT);
  // Result builds up from the top: after WIDTH shifts bit 0 lands at LSB.
  assign res_next = {fa_s, res_sr[WIDTH-1:1]};

  // NOTE: reset is synchronous and sampled in the clocked block, so it only
  // takes effect on a rising edge and outranks every other event there.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every output of this block is assigned a default first, so no
  // path through the case leaves a signal unassigned and no latch appears.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)    state_d = RUN;
      RUN:     if (last_bit) state_d = DONE;
      DONE:                  state_d = IDLE;
      default:               state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before this edge, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      bitcnt <= '0;
      carry  <= 1'b0;
      sum    <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_sr   <= a;
            b_sr   <= b_cap;
            carry  <= carry_cap;
            bitcnt <= '0;
            res_sr <= '0;
          end
        end
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= res_next;
          carry  <= fa_co;
          bitcnt <= bitcnt + CW'(1);
          if (last_bit) begin
            sum  <= res_next;
            cout <= fa_co;
            // 'carry' here is the carry entering the MSB.
            ovf  <= carry ^ fa_co;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder4.sv
// -----------------------------------------------------------------------------
// tb_serial_adder4
// Directed self-checking bench for serial_adder4 (WIDTH=4). Expected values
// are hand-computed constants. Define SERIAL_SUB_MODE_EN to also exercise
// the subtract path.
// -----------------------------------------------------------------------------
module tb_serial_adder4;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a, b;
  logic             cin;
  logic             sub;
  logic             busy, done, cout, ovf;
  logic [WIDTH-1:0] sum;

  int n_cmp = 0;
  int n_err = 0;

  serial_adder4 #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef SERIAL_SUB_MODE_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a one-cycle start; returns just after the accepting edge E0.
  task automatic start_op(input logic [3:0] ta, input logic [3:0] tb_, input logic tc,
                          input logic ts);
    start = 1'b1; a = ta; b = tb_; cin = tc; sub = ts;
    tick();
    start = 1'b0; a = 4'hx; b = 4'hx; cin = 1'bx; sub = 1'b0;
  endtask

  // Counts clocks from E0 (clock 1) until done is seen; bounded.
  task automatic wait_done(output int lat);
    lat = 1;
    while (!done && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [3:0] ta, input logic [3:0] tb_,
                        input logic tc, input logic ts, input logic [3:0] es,
                        input logic ec, input logic eo);
    int lat;
    start_op(ta, tb_, tc, ts);
    wait_done(lat);
    check({tag, "_latency"}, 16'(lat), 16'(WIDTH + 1));
    check({tag, "_sum"}, 16'(sum), 16'(es));
    check({tag, "_cout"}, 16'(cout), 16'(ec));
    check({tag, "_ovf"}, 16'(ovf), 16'(eo));
    check({tag, "_busy_done"}, 16'(busy), 16'd1);
    tick();
    check({tag, "_done_pulse"}, 16'(done), 16'd0);
    check({tag, "_idle"}, 16'(busy), 16'd0);
  endtask

  initial begin
    int lat, pulses;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    tick();
    tick();
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_done", 16'(done), 16'd0);
    check("rst_sum",  16'(sum),  16'd0);
    check("rst_cout", 16'(cout), 16'd0);
    check("rst_ovf",  16'(ovf),  16'd0);
    rst = 1'b0;
    tick();
    check("idle_nostart", 16'(busy), 16'd0);

    // 1: 3 + 5 = 8, signed overflow
    run_op("t1", 4'b0011, 4'b0101, 1'b0, 1'b0, 4'b1000, 1'b0, 1'b1);
    // 2: wrap-around and carry-in
    run_op("t2a", 4'b1111, 4'b0001, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0);
    run_op("t2b", 4'b0111, 4'b0000, 1'b1, 1'b0, 4'b1000, 1'b0, 1'b1);

    // 3: start during RUN is ignored
    start_op(4'b0001, 4'b0001, 1'b0, 1'b0);
    tick();
    start = 1'b1; a = 4'b1111; b = 4'b1111;
    tick();
    start = 1'b0;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) begin
        pulses++;
        check("t3_sum", 16'(sum), 16'b0010);
        check("t3_cout", 16'(cout), 16'd0);
      end
      tick();
    end
    check("t3_pulses", 16'(pulses), 16'd1);

    // 4: reset at the third RUN clock aborts
    start_op(4'b0110, 4'b0001, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t4_busy", 16'(busy), 16'd0);
    check("t4_sum", 16'(sum), 16'd0);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) pulses++;
      tick();
    end
    check("t4_no_done", 16'(pulses), 16'd0);
    run_op("t4b", 4'b0100, 4'b0010, 1'b0, 1'b0, 4'b0110, 1'b0, 1'b0);

    // 5: back-to-back, first result held until the second completes
    run_op("t5a", 4'b1001, 4'b1010, 1'b0, 1'b0, 4'b0011, 1'b1, 1'b1);
    start_op(4'b0110, 4'b0011, 1'b1, 1'b0);
    lat = 1;
    while (!done && lat < 20) begin
      check("t5_hold_sum", 16'(sum), 16'b0011);
      check("t5_hold_cout", 16'(cout), 16'd1);
      tick();
      lat++;
    end
    check("t5_latency", 16'(lat), 16'(WIDTH + 1));
    check("t5_sum", 16'(sum), 16'b1010);
    check("t5_cout", 16'(cout), 16'd0);
    check("t5_ovf", 16'(ovf), 16'd1);
    tick();

`ifdef SERIAL_SUB_MODE_EN
    // 6: subtract mode (cin must be ignored)
    run_op("t6a", 4'b0101, 4'b0011, 1'b0, 1'b1, 4'b0010, 1'b1, 1'b0);
    run_op("t6b", 4'b0011, 4'b0101, 1'b1, 1'b1, 4'b1110, 1'b0, 1'b0);
    run_op("t6c", 4'b0011, 4'b0101, 1'b0, 1'b0, 4'b1000, 1'b0, 1'b1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
